rx_frame_ctrl: RTL and testbench
================================

Name: rx_frame_ctrl

Overview:
Receive-side frame sequencer for the 8-bit AXI-Stream coming out of the tri-mode Ethernet MAC.
- Drives header_en so header_reg shifts in exactly the 14 header bytes.
- Filters on destination MAC once the header is complete.
- Forwards the payload as a registered byte stream with its own tlast/tuser.
- Emits per-frame status pulses and saturating statistics counters.
- Sits between the MAC rx AXIS port and the payload consumer, alongside header_reg.

Parameters:
- MAX_PAYLOAD, 1500, maximum payload bytes forwarded per frame; excess is truncated.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; asynchronous, active-low
- rx_axis_tdata  in  8  MAC rx byte
- rx_axis_tvalid  in  1  byte valid; no backpressure exists, every valid byte must be consumed
- rx_axis_tlast  in  1  last byte of frame
- rx_axis_tuser  in  1  bad-frame flag, meaningful with tlast
- rx_header  in  112  header_reg output: [111:64] dest MAC, [63:16] src MAC, [15:0] EtherType
- cfg_mac  in  48  local station MAC
- cfg_promisc  in  1  1 = accept any destination
- header_en  out  1  shift enable to header_reg
- hdr_valid  out  1  1-cycle pulse; rx_header complete and accepted
- pay_tdata  out  8  payload byte
- pay_tvalid  out  1  payload byte valid
- pay_tlast  out  1  last payload byte
- pay_tuser  out  1  with pay_tlast: frame bad (FCS error or truncated)
- frame_good  out  1  1-cycle pulse, accepted frame ended clean
- frame_filt  out  1  1-cycle pulse, frame rejected by address filter
- frame_err  out  1  1-cycle pulse, runt, tuser error or oversize
- cnt_good, cnt_filt, cnt_err  out  CNT_W each  saturating frame counters

Behaviour:
- Reset: state IDLE, byte counters 0, all outputs 0. Reset mid-frame abandons the frame; the remainder of that frame is not resynchronised, and the next tvalid is treated as byte 0.
- header_en is combinational: header_en = rx_axis_tvalid & (state==IDLE | state==HDR). No other path asserts it.
- States: IDLE, HDR, FILTER, PAYLOAD, DROP.
- IDLE: a valid byte is header byte 0; hdr_cnt<=1; go to HDR. If tlast is also set: runt, frame_err pulse, stay IDLE.
- HDR: each valid byte increments hdr_cnt. Gaps in tvalid hold the state.
  - tlast on any header byte, including byte 13: runt, frame_err, return to IDLE, nothing forwarded.
  - Byte 13 without tlast: go to FILTER.
- FILTER (exactly one cycle; rx_header now valid):
  - accept = cfg_promisc | dest==cfg_mac | dest==48'hFFFF_FFFF_FFFF.
  - accept: hdr_valid pulses; any valid byte this cycle is payload byte 0; go to PAYLOAD.
  - reject: go to DROP, and the FILTER-cycle byte is discarded.
  - A tlast in the FILTER cycle ends the frame exactly as the PAYLOAD or DROP end rules below.
- PAYLOAD: each valid byte is registered to pay_tdata/pay_tvalid with 1-cycle latency; pay_cnt increments.
  - On tlast: pay_tlast=1, pay_tuser=rx_axis_tuser, same cycle as the data. One cycle later, frame_good if tuser==0, else frame_err. Go to IDLE.
  - When byte number MAX_PAYLOAD is valid without tlast: output it with pay_tlast=1 and pay_tuser=1, pulse frame_err, go to DROP.
  - pay_tvalid is 0 on idle cycles.
- DROP: discard bytes until tlast, then go to IDLE. frame_filt pulses only for filter rejects; oversize was already counted at truncation.
- Back-to-back frames: a byte arriving the cycle after tlast is header byte 0 of the next frame (IDLE handling), with no lost byte.
- Counters increment with their pulses and saturate at all-ones.
- Exactly one status pulse per frame.

Decomposition:
- defines package: header struct (dest_mac, src_mac, eth_type, packed in the bit order above), MAC_BCAST constant, HDR_BYTES=14, rx_state_e enum.
- Sub-module: sat_counter (CNT_W, inc, saturating), instantiated three times. All other logic is inline.

Test Plan:
- Unicast frame: dest=cfg_mac=02:00:00:00:00:01, 14 header bytes + 46 payload bytes, tuser=0 → header_en high for exactly 14 cycles; rx_header[111:64]=48'h020000000001; 46 pay_tvalid beats with 1-cycle latency, pay_tlast on beat 46; frame_good pulse; cnt_good=1.
- Filtered frame: dest=02:00:00:00:00:99, cfg_promisc=0 → no pay_tvalid; frame_filt pulse; cnt_filt=1. Repeat with cfg_promisc=1 → forwarded, cnt_good increments.
- Runt: tlast on byte 9 → no payload, frame_err, cnt_err=1. Next frame, sent back-to-back on the following cycle, is parsed correctly.
- FCS error: broadcast dest, 60 bytes, tuser=1 with tlast → pay_tlast & pay_tuser=1, frame_err, cnt_good unchanged.
- Oversize with MAX_PAYLOAD=16: 40 payload bytes → exactly 16 beats, the 16th with pay_tlast=pay_tuser=1; remaining bytes dropped; one frame_err.
- Gaps and reset: tvalid toggled randomly through header and payload → identical output data. rst_n asserted in PAYLOAD → outputs 0 immediately; the next frame (header starting at the first tvalid after reset release) is parsed from byte 0.

Source files
------------

// File: rtl/rx_frame_ctrl_pkg.sv
// rx_frame_ctrl_pkg: shared types and constants for the receive frame sequencer
package rx_frame_ctrl_pkg;
  localparam int HDR_BYTES = 14;
  localparam logic [47:0] MAC_BCAST = 48'hFFFF_FFFF_FFFF;
  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
  } header_t;
  typedef enum logic [2:0] {IDLE, HDR, FILTER, PAYLOAD, DROP} rx_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: sequences MAC rx bytes into header_reg, filters on dest MAC,
// forwards payload with its own framing and emits per-frame status and counters
module rx_frame_ctrl
  import rx_frame_ctrl_pkg::*;
#(
  parameter int MAX_PAYLOAD = 1500,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_axis_tdata,
  input  logic             rx_axis_tvalid,
  input  logic             rx_axis_tlast,
  input  logic             rx_axis_tuser,
  input  logic [111:0]     rx_header,
  input  logic [47:0]      cfg_mac,
  input  logic             cfg_promisc,
  output logic             header_en,
  output logic             hdr_valid,
  output logic [7:0]       pay_tdata,
  output logic             pay_tvalid,
  output logic             pay_tlast,
  output logic             pay_tuser,
  output logic             frame_good,
  output logic             frame_filt,
  output logic             frame_err,
  output logic [CNT_W-1:0] cnt_good,
  output logic [CNT_W-1:0] cnt_filt,
  output logic [CNT_W-1:0] cnt_err
);
  localparam int PW = $clog2(MAX_PAYLOAD + 1);
  localparam logic [PW-1:0] PAY_LAST = PW'(MAX_PAYLOAD - 1);
  rx_state_e state, state_nx;
  header_t hdr;
  logic [3:0] hdr_cnt;
  logic [PW-1:0] pay_cnt;
  logic drop_filt;
  logic accept, last_hdr, end_in, fwd, full, trunc;
  logic runt, filt_end, good_end, bad_end;
  logic st_good, st_filt, st_err;
  assign hdr = header_t'(rx_header);
  assign accept = cfg_promisc | hdr.dest_mac == cfg_mac | hdr.dest_mac == MAC_BCAST;
  assign last_hdr = hdr_cnt == 4'(HDR_BYTES - 1);
  assign end_in = rx_axis_tvalid & rx_axis_tlast;
  assign full = pay_cnt == PAY_LAST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = rx_axis_tvalid && !rx_axis_tlast ? HDR : IDLE;
      HDR:     state_nx = !rx_axis_tvalid ? HDR : rx_axis_tlast ? IDLE : last_hdr ? FILTER : HDR;
      FILTER:  state_nx = end_in ? IDLE : (accept && !trunc) ? PAYLOAD : DROP;
      PAYLOAD: state_nx = end_in ? IDLE : trunc ? DROP : PAYLOAD;
      DROP:    state_nx = end_in ? IDLE : DROP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    header_en = rx_axis_tvalid & (state == IDLE | state == HDR);
    hdr_valid = state == FILTER & accept;
    fwd = rx_axis_tvalid & (state == PAYLOAD | hdr_valid);
    trunc = fwd & ~rx_axis_tlast & full;
    runt = end_in & (state == IDLE | state == HDR);
    filt_end = end_in & ((state == FILTER & ~accept) | (state == DROP & drop_filt));
    good_end = fwd & rx_axis_tlast & ~rx_axis_tuser;
    bad_end = (fwd & rx_axis_tlast & rx_axis_tuser) | trunc;
  end
  // status is staged twice so every frame end reports one cycle after pay_tlast timing
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hdr_cnt <= '0;
      pay_cnt <= '0;
      drop_filt <= 1'b0;
      pay_tdata <= '0;
      pay_tvalid <= 1'b0;
      pay_tlast <= 1'b0;
      pay_tuser <= 1'b0;
      {st_good, st_filt, st_err} <= '0;
      {frame_good, frame_filt, frame_err} <= '0;
    end else begin
      hdr_cnt <= state == IDLE ? {3'b0, rx_axis_tvalid} : (state == HDR && rx_axis_tvalid) ? hdr_cnt + 1'b1 : hdr_cnt;
      pay_cnt <= state == IDLE ? '0 : fwd ? pay_cnt + 1'b1 : pay_cnt;
      drop_filt <= state == FILTER ? ~accept : drop_filt;
      pay_tdata <= fwd ? rx_axis_tdata : pay_tdata;
      pay_tvalid <= fwd;
      pay_tlast <= fwd & (rx_axis_tlast | full);
      pay_tuser <= fwd & (rx_axis_tlast ? rx_axis_tuser : full);
      {st_good, st_filt, st_err} <= {good_end, filt_end, runt | bad_end};
      {frame_good, frame_filt, frame_err} <= {st_good, st_filt, st_err};
    end
  sat_counter #(.W(CNT_W)) u_cnt_good (.clk(clk), .rst_n(rst_n), .inc(frame_good), .cnt(cnt_good));
  sat_counter #(.W(CNT_W)) u_cnt_filt (.clk(clk), .rst_n(rst_n), .inc(frame_filt), .cnt(cnt_filt));
  sat_counter #(.W(CNT_W)) u_cnt_err  (.clk(clk), .rst_n(rst_n), .inc(frame_err),  .cnt(cnt_err));
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: directed frames against rx_frame_ctrl with a modelled header_reg
module tb_rx_frame_ctrl;
  localparam int MAXP = 48;
  logic clk = 0, rst_n = 0;
  logic [7:0] tdata = '0;
  logic tvalid = 0, tlast = 0, tuser = 0;
  logic [111:0] hreg = '0;
  logic [47:0] cfg_mac = 48'h020000000001;
  logic promisc = 0;
  logic header_en, hdr_valid, pay_tvalid, pay_tlast, pay_tuser;
  logic frame_good, frame_filt, frame_err;
  logic [7:0] pay_tdata;
  logic [15:0] cnt_good, cnt_filt, cnt_err;
  int checks = 0, errors = 0;
  int cyc = 0, last_cyc = 0, tlast_cyc = 0, good_cyc = 0;
  int hen_cnt = 0, hv_cnt = 0, n_good = 0, n_filt = 0, n_err = 0;
  int s_hen, s_hv, s_good, s_filt, s_err, s_q;
  logic [47:0] cap_dest = '0;
  logic [9:0] beats[$];

  rx_frame_ctrl #(.MAX_PAYLOAD(MAXP), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_axis_tdata(tdata), .rx_axis_tvalid(tvalid), .rx_axis_tlast(tlast), .rx_axis_tuser(tuser),
    .rx_header(hreg), .cfg_mac(cfg_mac), .cfg_promisc(promisc),
    .header_en(header_en), .hdr_valid(hdr_valid),
    .pay_tdata(pay_tdata), .pay_tvalid(pay_tvalid), .pay_tlast(pay_tlast), .pay_tuser(pay_tuser),
    .frame_good(frame_good), .frame_filt(frame_filt), .frame_err(frame_err),
    .cnt_good(cnt_good), .cnt_filt(cnt_filt), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  // stand-in for the external header_reg
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (header_en) hreg <= {hreg[103:0], tdata};
  end

  always @(negedge clk) begin
    if (header_en) hen_cnt = hen_cnt + 1;
    if (hdr_valid) begin hv_cnt = hv_cnt + 1; cap_dest = hreg[111:64]; end
    if (pay_tvalid) begin
      beats.push_back({pay_tlast, pay_tuser, pay_tdata});
      if (pay_tlast) tlast_cyc = cyc;
    end
    if (frame_good) begin n_good = n_good + 1; good_cyc = cyc; end
    if (frame_filt) n_filt = n_filt + 1;
    if (frame_err) n_err = n_err + 1;
  end

  function automatic logic [7:0] pb(input int j);
    return 8'(j * 3 + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      tvalid = 0; tlast = 0; tuser = 0;
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic l, input logic u, input bit gaps);
    if (gaps) while ($urandom_range(0, 1) == 1) idle(1);
    @(posedge clk); #1;
    tdata = d; tvalid = 1; tlast = l; tuser = u;
    last_cyc = cyc;
  endtask

  task automatic send(input logic [47:0] dest, input int npay, input bit bad, input bit gaps,
                      input int stop = 1000000);
    int total = 14 + npay;
    for (int i = 0; i < total && i < stop; i++) begin
      logic [7:0] b;
      b = i < 6 ? dest[47-8*i -: 8] : i < 12 ? 8'(8'h10 + i) : i == 12 ? 8'h08 : i == 13 ? 8'h00 : pb(i - 14);
      drive(b, i == total - 1, bad && i == total - 1, gaps);
    end
  endtask

  task automatic snap();
    s_hen = hen_cnt; s_hv = hv_cnt; s_good = n_good; s_filt = n_filt; s_err = n_err; s_q = beats.size();
  endtask

  task automatic check_frame(input string tag, input int nb, input bit user, input int g, input int f, input int e);
    int n = beats.size() - s_q;
    int bad = 0, nl = 0;
    for (int j = 0; j < n; j++) begin
      if (beats[s_q+j][7:0] !== pb(j)) bad++;
      if (beats[s_q+j][9]) nl++;
    end
    chk({tag, "_beats"}, n, nb);
    chk({tag, "_data"}, bad, 0);
    chk({tag, "_ntlast"}, nl, nb > 0 ? 1 : 0);
    if (n > 0) begin
      chk({tag, "_last_tlast"}, beats[beats.size()-1][9], 1);
      chk({tag, "_last_tuser"}, beats[beats.size()-1][8], user);
    end
    chk({tag, "_good"}, n_good - s_good, g);
    chk({tag, "_filt"}, n_filt - s_filt, f);
    chk({tag, "_err"}, n_err - s_err, e);
  endtask

  initial begin
    idle(3);
    chk("rst_header_en", header_en, 0);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_pay_tvalid", pay_tvalid, 0);
    chk("rst_cnts", {cnt_good, cnt_filt, cnt_err}, 0);
    rst_n = 1;
    idle(2);

    snap();
    send(cfg_mac, 46, 0, 0); idle(5);
    chk("uni_hen", hen_cnt - s_hen, 14);
    chk("uni_hv", hv_cnt - s_hv, 1);
    chk("uni_dest", cap_dest, 48'h020000000001);
    chk("uni_latency", tlast_cyc - last_cyc, 1);
    chk("uni_good_delay", good_cyc - tlast_cyc, 1);
    check_frame("uni", 46, 0, 1, 0, 0);
    chk("uni_cnt_good", cnt_good, 1);

    snap();
    send(48'h020000000099, 20, 0, 0); idle(5);
    chk("filt_hv", hv_cnt - s_hv, 0);
    check_frame("filt", 0, 0, 0, 1, 0);
    chk("filt_cnt", cnt_filt, 1);

    promisc = 1;
    snap();
    send(48'h020000000099, 20, 0, 0); idle(5);
    check_frame("promisc", 20, 0, 1, 0, 0);
    chk("promisc_cnt", cnt_good, 2);
    promisc = 0;

    snap();
    send(cfg_mac, -4, 0, 0);
    send(cfg_mac, 10, 0, 0); idle(5);
    chk("runt_hen", hen_cnt - s_hen, 24);
    check_frame("runt_b2b", 10, 0, 1, 0, 1);
    chk("runt_cnt_err", cnt_err, 1);
    chk("runt_cnt_good", cnt_good, 3);

    snap();
    send(48'hFFFF_FFFF_FFFF, 46, 1, 0); idle(5);
    check_frame("fcs", 46, 1, 0, 0, 1);
    chk("fcs_cnt_good", cnt_good, 3);
    chk("fcs_cnt_err", cnt_err, 2);

    snap();
    send(cfg_mac, 70, 0, 0); idle(5);
    check_frame("over", MAXP, 1, 0, 0, 1);
    chk("over_cnt_filt", cnt_filt, 1);

    snap();
    send(cfg_mac, MAXP, 0, 0); idle(5);
    check_frame("exact", MAXP, 0, 1, 0, 0);

    snap();
    send(cfg_mac, 30, 0, 1); idle(5);
    check_frame("gaps", 30, 0, 1, 0, 0);
    chk("gaps_cnt_good", cnt_good, 5);

    send(cfg_mac, 30, 0, 0, 20);
    @(posedge clk); #1;
    rst_n = 0; tvalid = 0; tlast = 0;
    #1;
    chk("midrst_pay_tvalid", pay_tvalid, 0);
    chk("midrst_cnt_good", cnt_good, 0);
    idle(2);
    rst_n = 1;
    snap();
    send(cfg_mac, 12, 0, 0); idle(5);
    chk("postrst_hen", hen_cnt - s_hen, 14);
    check_frame("postrst", 12, 0, 1, 0, 0);
    chk("postrst_cnt_good", cnt_good, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
